// File: rtl/south_link_tx.sv
// South-port link transmitter: credit-gated FIFO-to-link flit pump.
// Define LINK_PARITY_EN to add the registered even-parity output link_parity.
module south_link_tx #(
   parameter int unsigned CREDIT_MAX = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   output logic       fifo_rd,
   input  logic [7:0] fifo_data,
   output logic [7:0] link_data,
   output logic       link_valid,
   input  logic       credit_ret,
   output logic [3:0] credits,
   output logic       credit_err,
`ifdef LINK_PARITY_EN
   output logic       link_parity,
`endif
   output logic       busy
);

   localparam logic [3:0] CreditMax = 4'(CREDIT_MAX);

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StSend
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] credits_q, credits_d;
   logic       credit_err_q, credit_err_d;
   logic [7:0] link_data_q, link_data_d;
   logic       can_read;

   // Gating with rst keeps the strobe low while reset is held.
   assign can_read = !fifo_empty && (credits_q != 4'd0) && !rst;

   always_comb begin
      state_d = state_q;
      fifo_rd = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (can_read) begin
               fifo_rd = 1'b1;
               state_d = StFetch;
            end
         end
         StFetch: begin
            state_d = StSend;
         end
         StSend: begin
            if (can_read) begin
               fifo_rd = 1'b1;
               state_d = StFetch;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // The FIFO output is valid during FETCH, so it is captured on the FETCH->SEND edge.
   always_comb begin
      link_data_d = link_data_q;
      if (state_q == StFetch) begin
         link_data_d = fifo_data;
      end
   end

   // Credits are reserved on read; a return at full depth is an overflow.
   always_comb begin
      credits_d    = credits_q;
      credit_err_d = credit_err_q;
      if (fifo_rd && !credit_ret) begin
         credits_d = credits_q - 4'd1;
      end else if (credit_ret && !fifo_rd) begin
         if (credits_q >= CreditMax) begin
            credit_err_d = 1'b1;
         end else begin
            credits_d = credits_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         credits_q    <= CreditMax;
         credit_err_q <= 1'b0;
         link_data_q  <= 8'h00;
      end else begin
         state_q      <= state_d;
         credits_q    <= credits_d;
         credit_err_q <= credit_err_d;
         link_data_q  <= link_data_d;
      end
   end

`ifdef LINK_PARITY_EN
   logic link_parity_q, link_parity_d;

   always_comb begin
      link_parity_d = link_parity_q;
      if (state_q == StFetch) begin
         link_parity_d = ^fifo_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         link_parity_q <= 1'b0;
      end else begin
         link_parity_q <= link_parity_d;
      end
   end

   assign link_parity = link_parity_q;
`endif

   assign link_data  = link_data_q;
   assign link_valid = (state_q == StSend);
   assign credits    = credits_q;
   assign credit_err = credit_err_q;
   assign busy       = (state_q != StIdle);

endmodule
